// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable almost-full and
// almost-empty thresholds and sticky overflow/underflow error flags.
//
// Optional build macro:
//   SYNC_FIFO_FWFT_EN  - first-word-fall-through read mode. data_out shows mem[rd_ptr]
//                        combinationally and is valid whenever empty=0. When undefined,
//                        data_out is registered and updates one edge after an accepted rd.
//
// Parameters:
//   DATA_WIDTH  width of data_in/data_out (>=1)
//   DEPTH       number of entries (>=2, any value, not limited to powers of two)
//   AF_LEVEL    almost_full  when fifo_cnt >= AF_LEVEL
//   AE_LEVEL    almost_empty when fifo_cnt <= AE_LEVEL
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, priority over every other input
//   data_in       write data
//   wr / rd       write / read requests
//   err_clr       synchronous clear of overflow/underflow (a coincident set wins)
//   data_out      read data
//   empty, full, almost_empty, almost_full
//                 decodes of the registered occupancy
//   fifo_cnt      current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         wr,
  input  logic                         rd,
  input  logic                         err_clr,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfLevel = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLevel = CntW'(AE_LEVEL);

  // Storage; intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;
  logic mem_we;

  // Status decodes of the registered count, so they reflect the post-edge state.
  always_comb begin
    empty        = (fifo_cnt_q == '0);
    full         = (fifo_cnt_q == CntFull);
    almost_empty = (fifo_cnt_q <= AeLevel);
    almost_full  = (fifo_cnt_q >= AfLevel);
  end

  // A write into a full FIFO is still accepted when a read frees a slot on the same
  // edge. A read of an empty FIFO is never satisfied by a same-cycle write (no bypass).
  always_comb begin
    rd_ok  = rd & ~empty;
    wr_ok  = wr & (~full | rd);
    mem_we = wr_ok & ~rst;
  end

  // Pointer, count and error-flag next state.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Explicit wrap so DEPTH need not be a power of two.
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // Clear first, then set, so a coincident set wins over err_clr.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr && full && !rd) begin
      overflow_d = 1'b1;
    end
    if (rd && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is always visible; undefined content while empty.
  always_comb begin
    data_out = mem_q[rd_ptr_q];
  end
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Registered read: capture the head on an accepted read, otherwise hold.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_ok) begin
      data_out_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    data_out = data_out_q;
  end
`endif

  always_comb begin
    fifo_cnt  = fifo_cnt_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          wr;
  logic          rd;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [3:0]    fifo_cnt;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr           (wr),
    .rd           (rd),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_cnt     (fifo_cnt),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // One stimulus record: inputs plus hand-derived post-edge count and error flags.
  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] din;
    int            cnt;
    bit            ov;
    bit            un;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];       // scoreboard of words expected to come out
  logic [DW-1:0] exp_dout;
  int            checks = 0;
  int            errors = 0;

  task automatic add(input logic r, input logic w, input logic d, input logic c,
                     input int din, input int cnt, input bit ov, input bit un);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.clr = c; v.din = DW'(din);
    v.cnt = cnt; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] head;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = '0;
    exp_dout = '0;

    // Basic write three / read three.
    add(1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0, 0, 10, 1, 0, 0);
    add(0, 1, 0, 0, 20, 2, 0, 0);
    add(0, 1, 0, 0, 30, 3, 0, 0);
    add(0, 0, 1, 0, 0,  2, 0, 0);
    add(0, 0, 1, 0, 0,  1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 0);
    // Fill with 1..8, then overflow, set-beats-clear, clear.
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, i, i, 0, 0);
    add(0, 1, 0, 0, 77, 8, 1, 0);
    add(0, 1, 0, 1, 78, 8, 1, 0);
    add(0, 0, 0, 1, 0,  8, 0, 0);
    // Simultaneous access while full, then drain.
    add(0, 1, 1, 0, 99, 8, 0, 0);
    for (int i = 7; i >= 0; i--) add(0, 0, 1, 0, 0, i, 0, 0);
    // Simultaneous access while empty: write only, underflow sets.
    add(0, 1, 1, 0, 5, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Pointer wrap: fill to 4, alternate, then sustained simultaneous traffic.
    for (int i = 1; i <= 4; i++) add(0, 1, 0, 0, 100 + i, i, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) add(0, 1, 0, 0, $urandom_range(0, 255), 5, 0, 0);
      else            add(0, 0, 1, 0, 0, 4, 0, 0);
    end
    for (int i = 0; i < 12; i++) add(0, 1, 1, 0, $urandom_range(0, 255), 4, 0, 0);
    // Reach cnt=5 with overflow set, then reset mid-stream.
    for (int i = 5; i <= 8; i++) add(0, 1, 0, 0, 200 + i, i, 0, 0);
    add(0, 1, 0, 0, 250, 8, 1, 0);
    for (int i = 7; i >= 5; i--) add(0, 0, 1, 0, 0, i, 1, 0);
    add(1, 1, 1, 0, 33, 0, 0, 0);
    add(0, 1, 0, 0, 42, 1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      rst = v.rst; wr = v.wr; rd = v.rd; err_clr = v.clr; data_in = v.din;

      // Scoreboard update from the bench's own view of occupancy.
      if (v.rst) begin
        sb.delete();
        exp_dout = '0;
      end else begin
        cnt = sb.size();
        if (v.rd && cnt > 0) begin
          head = sb.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
          #1 check("fwft_head", i, int'(data_out), int'(head));
`endif
          exp_dout = head;
        end
        if (v.wr && (cnt < DEPTH || v.rd)) sb.push_back(v.din);
      end

      @(posedge clk);
      #1;
      check("fifo_cnt",     i, int'(fifo_cnt),     v.cnt);
      check("empty",        i, int'(empty),        int'(v.cnt == 0));
      check("full",         i, int'(full),         int'(v.cnt == DEPTH));
      check("almost_empty", i, int'(almost_empty), int'(v.cnt <= AE));
      check("almost_full",  i, int'(almost_full),  int'(v.cnt >= AF));
      check("overflow",     i, int'(overflow),     int'(v.ov));
      check("underflow",    i, int'(underflow),    int'(v.un));
`ifndef SYNC_FIFO_FWFT_EN
      check("data_out",     i, int'(data_out),     int'(exp_dout));
`endif
      @(negedge clk);
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: a written word is visible before any read.
    rst = 1'b0; wr = 1'b1; rd = 1'b0; err_clr = 1'b0; data_in = 8'd42;
    @(posedge clk);
    #1 wr = 1'b0;
    check("fwft_first_word", -1, int'(data_out), 42);
    check("fwft_not_empty",  -1, int'(empty),    0);
`endif

    wr = 1'b0; rd = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit fixed-depth FIFO.
- Generalised in data width and depth.
- Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a defined full/empty simultaneous-access policy.
- Optional first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits (≥1).
- DEPTH, 8, number of storage entries (≥2; need not be a power of 2).
- AF_LEVEL, 6, almost_full asserts when fifo_cnt ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when fifo_cnt ≤ AE_LEVEL (0..DEPTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- wr  input  1  write request.
- rd  input  1  read request.
- err_clr  input  1  clears overflow/underflow (synchronous).
- data_out  output  DATA_WIDTH  read data.
- empty  output  1  fifo_cnt == 0.
- full  output  1  fifo_cnt == DEPTH.
- almost_empty  output  1  fifo_cnt ≤ AE_LEVEL.
- almost_full  output  1  fifo_cnt ≥ AF_LEVEL.
- fifo_cnt  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky: write was rejected.
- underflow  output  1  sticky: read was rejected.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high on rst; all state updates on the rising edge of clk.
- Reset values: rd_ptr=0, wr_ptr=0, fifo_cnt=0, data_out=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0).
  - Memory contents are not reset.
  - rst has priority over all other inputs, including mid-stream; contents are discarded.
- Pointers are binary indices 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not modulo power of 2).
- Write accepted (wr_ok) when wr && (!full || rd): mem[wr_ptr] ← data_in, wr_ptr advances.
- Read accepted (rd_ok) when rd && !empty: rd_ptr advances.
  - Standard mode: data_out ← mem[rd_ptr] at the same edge, so read latency is 1 cycle.
  - data_out holds its value when no read is accepted.
- Simultaneous wr and rd:
  - Not empty and not full: both accepted, fifo_cnt unchanged.
  - Full: both accepted; the write uses the slot freed by the read, fifo_cnt stays DEPTH, no overflow.
  - Empty: write accepted, read rejected (no bypass), fifo_cnt becomes 1, underflow sets.
- fifo_cnt next value: +1 if wr_ok && !rd_ok; −1 if rd_ok && !wr_ok; otherwise unchanged. It never exceeds DEPTH and never goes below 0.
- Flags are combinational decodes of the registered fifo_cnt, so they reflect the post-edge state.
- Error flags:
  - overflow sets on wr && full && !rd.
  - underflow sets on rd && empty.
  - Both clear on rst or err_clr. If set and clear conditions coincide, set wins.
  - Rejected operations leave pointers, count, memory and data_out unchanged.
- No FSM beyond the pointer/count registers. The implementation must not infer a latch.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally and is valid whenever empty=0.
  - The first written word appears on data_out in the cycle after the write edge.
  - A rd with !empty consumes the displayed word; the next word is shown after the edge.
  - data_out while empty is don't-care. All flag, count and error rules are unchanged.
- Undefined: standard registered-read mode as described above.

Test Plan (DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset then write 10,20,30 on 3 cycles → fifo_cnt=3, empty=0, almost_empty=0 after 3rd write; then rd for 3 cycles → data_out 10,20,30 each 1 cycle after its rd edge, then empty=1.
- Write 8 words 1..8 → full=1, almost_full=1 from cnt=6; a 9th wr alone → rejected, overflow=1, fifo_cnt=8; err_clr pulse → overflow=0.
- Full, assert wr=1 (data 99) and rd=1 together → data_out=1, fifo_cnt=8, overflow=0; drain 8 words → 2..8 then 99.
- Empty, wr=1 (data 5) and rd=1 together → fifo_cnt=1, underflow=1, data_out unchanged; next rd → data_out=5, empty=1.
- Pointer wrap: run 20 cycles of alternating write/read plus sustained simultaneous wr/rd at cnt=4 → output sequence equals input sequence, fifo_cnt constant at 4.
- Assert rst while fifo_cnt=5 and overflow=1 → next cycle fifo_cnt=0, empty=1, overflow=0, data_out=0; in SYNC_FIFO_FWFT_EN build, write 42 → data_out=42 before any rd.
